// File: rtl/booth_arb_pkg.sv
// Shared definitions for the Booth-multiplier arbiter: state encoding,
// datapath widths and the default multiplier settle time.
package booth_arb_pkg;

  localparam int unsigned OP_W           = 25;
  localparam int unsigned PROD_W         = 48;
  localparam int unsigned MUL_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/booth_arbiter_mul.sv
// Combinational radix-4 Booth multiplier; p is the low PROD_W bits of
// the signed product a*b.
module booth_arbiter_mul
  import booth_arb_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);

  always_comb begin
    logic [PROD_W-1:0] xe;
    logic [PROD_W-1:0] pp;
    logic [PROD_W-1:0] acc;
    logic [OP_W+1:0]   yb;
    logic [2:0]        grp;

    xe  = {{(PROD_W - OP_W){a[OP_W-1]}}, a};
    // Sign-extend b to an even width and append the implicit b[-1] = 0.
    yb  = {b[OP_W-1], b, 1'b0};
    acc = '0;
    for (int unsigned i = 0; i < (OP_W + 1) / 2; i++) begin
      grp = yb[2*i +: 3];
      case (grp)
        3'b001, 3'b010: pp = xe;
        3'b011:         pp = xe << 1;
        3'b100:         pp = -(xe << 1);
        3'b101, 3'b110: pp = -xe;
        default:        pp = '0;
      endcase
      acc = acc + (pp << (2 * i));
    end
    p = acc;
  end

endmodule

// File: rtl/booth_arbiter.sv
// Two-requester arbiter in front of a shared multicycle Booth multiplier;
// one operation in flight, result held on a shared bus until consumed.
module booth_arbiter
  import booth_arb_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_x,
  input  logic [OP_W-1:0]   req0_y,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_x,
  input  logic [OP_W-1:0]   req1_y,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [PROD_W-1:0] rsp_p,
  output logic              busy
);

  localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [OP_W-1:0]     op_x_q, op_x_d;
  logic [OP_W-1:0]     op_y_q, op_y_d;
  logic [PROD_W-1:0]   rsp_p_q, rsp_p_d;
  logic [PROD_W-1:0]   mul_p;
  logic                grant;
  logic                owner_ready;

  // op_*_q -> rsp_p_q is a MUL_CYCLES multicycle path; operands stay
  // frozen for the whole CALC phase.
  booth_arbiter_mul u_mul (
    .a (op_x_q),
    .b (op_y_q),
    .p (mul_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      op_x_q       <= '0;
      op_y_q       <= '0;
      rsp_p_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      op_x_q       <= op_x_d;
      op_y_q       <= op_y_d;
      rsp_p_q      <= rsp_p_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    op_x_d       = op_x_q;
    op_y_d       = op_y_q;
    rsp_p_d      = rsp_p_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;

    // On a tie the requester that did not win last time goes first.
    grant       = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    owner_ready = owner_q ? rsp1_ready : rsp0_ready;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = ~grant & ~rst;
          req1_ready =  grant & ~rst;
          owner_d    = grant;
          op_x_d     = grant ? req1_x : req0_x;
          op_y_d     = grant ? req1_y : req0_y;
          cnt_d      = CNT_INIT;
          state_d    = CALC;
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          rsp_p_d = mul_p;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        rsp0_valid = ~owner_q;
        rsp1_valid =  owner_q;
        if (owner_ready) begin
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_p = rsp_p_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_booth_arbiter.sv
// Randomised scoreboard bench for booth_arbiter: a transaction-level model
// predicts grants, products and response timing; a monitor checks the bus.
module tb_booth_arbiter;

  localparam int M = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [24:0] req0_x, req0_y, req1_x, req1_y;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [47:0] rsp_p;
  logic        busy;

  booth_arbiter #(.MUL_CYCLES(M)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_p      (rsp_p),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        owner;
    logic [47:0] p;
    int          due;
  } exp_t;

  exp_t   expq[$];
  exp_t   e;
  logic   grants[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     hold = 0;
  bit     tie_ready = 1'b0;
  bit     measure = 1'b0;
  bit     have_hs = 1'b0;
  int     last_hs = 0;
  int     hs_count = 0;
  bit     m_busy, m_last, m_owner, holding, held_owner;
  int     m_due;
  logic [47:0] held_p;

  function automatic logic [47:0] ref_prod(input logic [24:0] a, input logic [24:0] b);
    longint sa, sb, pr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    pr = sa * sb;
    return pr[47:0];
  endfunction

  function automatic logic [24:0] rand_op();
    case ($urandom_range(0, 4))
      0:       return 25'h0FFFFFF;
      1:       return 25'h1000000;
      2:       return 25'h1FFFFFF;
      3:       return 25'h0000000;
      default: return 25'($urandom);
    endcase
  endfunction

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk48(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %012h expected %012h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response sink: non-owner and out-of-DONE ready lines toggle randomly.
  initial begin
    int c0, c1;
    c0 = 0;
    c1 = 0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tie_ready) begin
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
      end else begin
        if (rsp0_valid) begin rsp0_ready = (c0 >= hold); c0++; end
        else begin c0 = 0; rsp0_ready = 1'($urandom_range(0, 1)); end
        if (rsp1_valid) begin rsp1_ready = (c1 >= hold); c1++; end
        else begin c1 = 0; rsp1_ready = 1'($urandom_range(0, 1)); end
      end
    end
  end

  // Reference model and response monitor, sampled on the falling edge.
  initial forever begin
    logic any, w;
    @(negedge clk);
    if (rst) begin
      chk1("rst_req0_ready", req0_ready, 1'b0);
      chk1("rst_req1_ready", req1_ready, 1'b0);
      chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
      chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk48("rst_rsp_p", rsp_p, 48'h0);
      expq.delete();
      m_busy  = 1'b0;
      m_last  = 1'b1;
      holding = 1'b0;
    end else begin
      chk1("dual_valid", rsp0_valid & rsp1_valid, 1'b0);
      if (rsp0_valid || rsp1_valid) begin
        if (!holding) begin
          if (expq.size() == 0) begin
            chk1("unexpected_rsp", 1'b1, 1'b0);
          end else begin
            e = expq.pop_front();
            chk1("rsp_owner", rsp1_valid, e.owner);
            chk48("rsp_p", rsp_p, e.p);
            chki("rsp_latency", cyc, e.due);
            held_p     = rsp_p;
            held_owner = rsp1_valid;
            holding    = 1'b1;
          end
        end else begin
          chk48("rsp_p_stable", rsp_p, held_p);
          chk1("rsp_owner_stable", rsp1_valid, held_owner);
        end
        if (rsp1_valid ? rsp1_ready : rsp0_ready) holding = 1'b0;
      end

      chk1("busy", busy, m_busy);
      if (!m_busy) begin
        any = req0_valid | req1_valid;
        w   = (req0_valid && req1_valid) ? !m_last : req1_valid;
        chk1("req0_ready", req0_ready, any && !w);
        chk1("req1_ready", req1_ready, any && w);
        if (any) begin
          expq.push_back('{owner: w,
                           p: ref_prod(w ? req1_x : req0_x, w ? req1_y : req0_y),
                           due: cyc + M + 1});
          if (measure && have_hs) chki("issue_interval", cyc - last_hs, M + 2);
          have_hs = 1'b1;
          last_hs = cyc;
          hs_count++;
          grants.push_back(w);
          m_busy  = 1'b1;
          m_owner = w;
          m_due   = cyc + M + 1;
        end
      end else begin
        chk1("req0_ready_busy", req0_ready, 1'b0);
        chk1("req1_ready_busy", req1_ready, 1'b0);
        if (cyc >= m_due && (m_owner ? rsp1_ready : rsp0_ready)) begin
          m_busy = 1'b0;
          m_last = m_owner;
        end
      end
    end
  end

  task automatic issue(input bit n, input logic [24:0] x, input logic [24:0] y);
    bit seen;
    seen = 1'b0;
    if (n) begin req1_valid = 1'b1; req1_x = x; req1_y = y; end
    else   begin req0_valid = 1'b1; req0_x = x; req0_y = y; end
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = n ? req1_ready : req0_ready;
    end
    if (!seen) fail("handshake_timeout");
    @(posedge clk);
    #1;
    if (n) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(input bit n, input logic [47:0] exp);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = n ? rsp1_valid : rsp0_valid;
    end
    if (!seen) fail("rsp_timeout");
    else chk48("directed_p", rsp_p, exp);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge clk);
      idle = !busy && !m_busy && expq.size() == 0 && !rsp0_valid && !rsp1_valid;
    end
    if (!idle) fail("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_g[4];
    int   base;
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(1'b0, 25'h0800000, 25'h0800000);
    wait_rsp(1'b0, 48'h400000000000);
    wait_idle();
    issue(1'b1, 25'h0FFFFFF, 25'h0FFFFFF);
    wait_rsp(1'b1, 48'hFFFFFE000001);
    wait_idle();
    issue(1'b1, 25'h1FFFFFF, 25'h0000003);
    wait_rsp(1'b1, 48'hFFFFFFFFFFFD);
    wait_idle();

    // Contention: both requesters valid throughout, slow consumer.
    hold = 5;
    grants.delete();
    req0_valid = 1'b1; req0_x = 25'h0123456; req0_y = 25'h1ABCDEF;
    req1_valid = 1'b1; req1_x = 25'h1000000; req1_y = 25'h0FFFFFF;
    for (int i = 0; i < 200 && grants.size() < 4; i++) @(negedge clk);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (grants.size() < 4) fail("contention_grants");
    else for (int i = 0; i < 4; i++) chk1("grant_order", grants[i], exp_g[i]);
    wait_idle();
    hold = 0;

    // Reset while the operation is still in CALC.
    issue(1'b0, 25'h0054321, 25'h0012345);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    issue(1'b1, 25'h0000007, 25'h1FFFFF9);
    wait_rsp(1'b1, 48'hFFFFFFFFFFCF);
    wait_idle();

    // Same-cycle consume: back-to-back issue interval.
    tie_ready = 1'b1;
    measure   = 1'b1;
    have_hs   = 1'b0;
    base      = hs_count;
    req0_valid = 1'b1;
    for (int i = 0; i < 100 && hs_count < base + 5; i++) begin
      req0_x = rand_op();
      req0_y = rand_op();
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    if (hs_count < base + 5) fail("back_to_back");
    wait_idle();
    measure   = 1'b0;
    tie_ready = 1'b0;

    for (int i = 0; i < 600; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_x = rand_op(); req0_y = rand_op();
      req1_x = rand_op(); req1_y = rand_op();
      hold = int'($urandom_range(0, 3));
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    hold = 0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
